// File: rtl/ifmap_glb_loader.sv
// Walks an ifmap tile in GLB word-major order, issues one 32-bit read per word and
// pushes the returned word into the target row's ifmap FIFO one cycle later.
module ifmap_glb_loader #(
    parameter int NUM_ROWS = 32,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   base_addr_i,
    input  logic [ADDR_W-1:0]   row_stride_i,
    input  logic [5:0]          active_rows_i,
    input  logic [15:0]         words_per_row_i,
    output logic                glb_rd_en_o,
    output logic [ADDR_W-1:0]   glb_addr_o,
    input  logic [DATA_W-1:0]   glb_rdata_i,
    input  logic [NUM_ROWS-1:0] ifmap_fifo_full_i,
    output logic [NUM_ROWS-1:0] push_ifmap_en_o,
    output logic [DATA_W-1:0]   push_ifmap_data_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam logic [ADDR_W-1:0]   WORD_BYTES = ADDR_W'(4);
    localparam logic [NUM_ROWS-1:0] ROW_ONE    = NUM_ROWS'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         rows_q, rows_d;
    logic [15:0]        words_q, words_d;
    logic [ADDR_W-1:0]  stride_q, stride_d;
    logic [5:0]         row_q, row_d;
    logic [15:0]        word_q, word_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  col_addr_q, col_addr_d;
    logic               inflight_q, inflight_d;
    logic [ROW_W-1:0]   inflight_row_q, inflight_row_d;

    logic               last_row;
    logic               last_word;
    logic               blocked;

    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise paths that
        // skip an assignment would infer latches.
        state_d           = state_q;
        rows_d            = rows_q;
        words_d           = words_q;
        stride_d          = stride_q;
        row_d             = row_q;
        word_d            = word_q;
        addr_d            = addr_q;
        col_addr_d        = col_addr_q;
        inflight_d        = 1'b0;
        inflight_row_d    = inflight_row_q;
        glb_rd_en_o       = 1'b0;
        glb_addr_o        = '0;
        push_ifmap_en_o   = '0;
        push_ifmap_data_o = '0;
        done_o            = 1'b0;
        busy_o            = (state_q != S_IDLE);

        last_row  = (row_q == rows_q - 6'd1);
        last_word = (word_q == words_q - 16'd1);
        // Same-row block keeps a single-row tile from pushing twice before full updates.
        blocked   = ifmap_fifo_full_i[row_q[ROW_W-1:0]] ||
                    (inflight_q && (inflight_row_q == row_q[ROW_W-1:0]));

        // The FIFO full check happened at issue time, so the push is unconditional.
        if (inflight_q) begin
            push_ifmap_en_o   = ROW_ONE << inflight_row_q;
            push_ifmap_data_o = glb_rdata_i;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    rows_d     = active_rows_i;
                    words_d    = words_per_row_i;
                    stride_d   = row_stride_i;
                    row_d      = '0;
                    word_d     = '0;
                    addr_d     = base_addr_i;
                    col_addr_d = base_addr_i;
                    state_d    = (active_rows_i == 6'd0 || words_per_row_i == 16'd0)
                                 ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (!blocked) begin
                    glb_rd_en_o    = 1'b1;
                    glb_addr_o     = addr_q;
                    inflight_d     = 1'b1;
                    inflight_row_d = row_q[ROW_W-1:0];
                    if (last_row) begin
                        row_d      = '0;
                        word_d     = word_q + 16'd1;
                        col_addr_d = col_addr_q + WORD_BYTES;
                        addr_d     = col_addr_q + WORD_BYTES;
                        if (last_word) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        row_d  = row_q + 6'd1;
                        addr_d = addr_q + stride_q;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q        <= S_IDLE;
            rows_q         <= '0;
            words_q        <= '0;
            stride_q       <= '0;
            row_q          <= '0;
            word_q         <= '0;
            addr_q         <= '0;
            col_addr_q     <= '0;
            inflight_q     <= 1'b0;
            inflight_row_q <= '0;
        end else begin
            state_q        <= state_d;
            rows_q         <= rows_d;
            words_q        <= words_d;
            stride_q       <= stride_d;
            row_q          <= row_d;
            word_q         <= word_d;
            addr_q         <= addr_d;
            col_addr_q     <= col_addr_d;
            inflight_q     <= inflight_d;
            inflight_row_q <= inflight_row_d;
        end
    end

endmodule

// File: tb/tb_ifmap_glb_loader.sv
// Scoreboard bench for ifmap_glb_loader: a tile model fills read/push queues at start,
// a negedge monitor pops and compares, and a GLB responder answers reads one cycle later.
module tb_ifmap_glb_loader;

    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [31:0]   base_addr_i;
    logic [31:0]   row_stride_i;
    logic [5:0]    active_rows_i;
    logic [15:0]   words_per_row_i;
    logic          glb_rd_en_o;
    logic [31:0]   glb_addr_o;
    logic [31:0]   glb_rdata_i;
    logic [NR-1:0] ifmap_fifo_full_i;
    logic [NR-1:0] push_ifmap_en_o;
    logic [31:0]   push_ifmap_data_o;
    logic          busy_o;
    logic          done_o;

    always #5 clk = ~clk;

    ifmap_glb_loader #(.NUM_ROWS(NR), .DATA_W(32), .ADDR_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .start_i           (start_i),
        .base_addr_i       (base_addr_i),
        .row_stride_i      (row_stride_i),
        .active_rows_i     (active_rows_i),
        .words_per_row_i   (words_per_row_i),
        .glb_rd_en_o       (glb_rd_en_o),
        .glb_addr_o        (glb_addr_o),
        .glb_rdata_i       (glb_rdata_i),
        .ifmap_fifo_full_i (ifmap_fifo_full_i),
        .push_ifmap_en_o   (push_ifmap_en_o),
        .push_ifmap_data_o (push_ifmap_data_o),
        .busy_o            (busy_o),
        .done_o            (done_o)
    );

    typedef struct {
        logic [31:0] addr;
        int          row;
    } rd_t;

    typedef struct {
        int          row;
        logic [31:0] data;
    } push_t;

    rd_t   exp_reads[$];
    push_t exp_pushes[$];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          active, exp_busy, done_seen, empty_tile;
    bit          prev_rd;
    int          prev_row;
    int          last_rd_cyc, start_cyc;
    bit          rsp_pend;
    logic [31:0] rsp_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Contents of GLB as seen by the loader: a fixed scramble of the byte address.
    function automatic logic [31:0] glb_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // GLB responder: data for a read seen in cycle t is presented throughout cycle t+1.
    initial begin
        glb_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            glb_rdata_i = rsp_pend ? glb_word(rsp_addr) : $urandom;
        end
    end

    // Monitor / scoreboard.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_rd  = 1'b0;
            rsp_pend = 1'b0;
        end else begin
            check("busy", busy_o, exp_busy);
            check("push_latency", push_ifmap_en_o != '0, prev_rd);
            if (push_ifmap_en_o != '0) begin
                check("push_onehot", $countones(push_ifmap_en_o), 1);
                if (exp_pushes.size() == 0) begin
                    check("unexpected_push", push_ifmap_en_o, 0);
                end else begin
                    push_t p;
                    logic [NR-1:0] oh;
                    p  = exp_pushes.pop_front();
                    oh = NR'(1) << p.row;
                    check("push_row", push_ifmap_en_o, oh);
                    check("push_data", push_ifmap_data_o, p.data);
                end
            end
            if (glb_rd_en_o) begin
                if (exp_reads.size() == 0) begin
                    check("unexpected_read", glb_rd_en_o, 0);
                    prev_rd = 1'b0;
                end else begin
                    rd_t e;
                    e = exp_reads.pop_front();
                    check("rd_addr", glb_addr_o, e.addr);
                    check("rd_while_full", ifmap_fifo_full_i[e.row], 0);
                    check("rd_same_row_inflight", prev_rd && prev_row == e.row, 0);
                    prev_rd     = 1'b1;
                    prev_row    = e.row;
                    last_rd_cyc = cyc;
                end
                rsp_pend = 1'b1;
                rsp_addr = glb_addr_o;
            end else begin
                check("addr_idle", glb_addr_o, 0);
                if (active && exp_reads.size() > 0) begin
                    if (!ifmap_fifo_full_i[exp_reads[0].row] &&
                        !(prev_rd && prev_row == exp_reads[0].row))
                        check("no_stall", glb_rd_en_o, 1);
                end
                prev_rd  = 1'b0;
                rsp_pend = 1'b0;
            end
            if (done_o) begin
                check("done_expected", done_o, active);
                if (active) begin
                    check("reads_left_at_done", exp_reads.size(), 0);
                    check("pushes_left_at_done", exp_pushes.size(), 0);
                    if (empty_tile)
                        check("done_delay_empty", (cyc - start_cyc) >= 1 && (cyc - start_cyc) <= 2, 1);
                    else
                        check("done_delay", cyc - last_rd_cyc, 2);
                    done_seen = 1'b1;
                    active    = 1'b0;
                    exp_busy  = 1'b0;
                end
            end
        end
    end

    // Reference model: word-major walk, addresses wrap at 2^32.
    task automatic load_model(input logic [31:0] b, input logic [31:0] s, input int rows, input int words);
        for (int w = 0; w < words; w++) begin
            for (int r = 0; r < rows; r++) begin
                logic [31:0] a;
                a = b + 32'(r) * s + 32'(w * 4);
                exp_reads.push_back('{addr: a, row: r});
                exp_pushes.push_back('{row: r, data: glb_word(a)});
            end
        end
    endtask

    task automatic issue_start(input logic [31:0] b, input logic [31:0] s, input int rows, input int words);
        load_model(b, s, rows, words);
        tick();
        start_i         = 1'b1;
        base_addr_i     = b;
        row_stride_i    = s;
        active_rows_i   = 6'(rows);
        words_per_row_i = 16'(words);
        start_cyc       = cyc;
        empty_tile      = (rows == 0 || words == 0);
        done_seen       = 1'b0;
        tick();
        start_i         = 1'b0;
        base_addr_i     = $urandom;
        row_stride_i    = $urandom;
        active_rows_i   = 6'($urandom_range(1, 32));
        words_per_row_i = 16'($urandom_range(1, 9));
        active          = 1'b1;
        exp_busy        = 1'b1;
    endtask

    task automatic drop_tile();
        exp_reads.delete();
        exp_pushes.delete();
        active   = 1'b0;
        exp_busy = 1'b0;
    endtask

    // full_mode: 0 none, 1 random flags, 2 row 1 held full for 5 cycles after start.
    task automatic run_tile(input logic [31:0] b, input logic [31:0] s, input int rows,
                            input int words, input int full_mode, input bit poke_start);
        if (full_mode == 2) ifmap_fifo_full_i = NR'(2);
        issue_start(b, s, rows, words);
        for (int i = 0; i < 4000 && !done_seen; i++) begin
            start_i = 1'b0;
            if (full_mode == 1) ifmap_fifo_full_i = $urandom & $urandom;
            if (full_mode == 2 && i == 4) ifmap_fifo_full_i = '0;
            if (poke_start && (i % 3) == 1) begin
                start_i         = 1'b1;
                base_addr_i     = $urandom;
                active_rows_i   = 6'($urandom_range(1, 32));
                words_per_row_i = 16'($urandom_range(1, 9));
            end
            tick();
        end
        start_i           = 1'b0;
        ifmap_fifo_full_i = '0;
        check("done_seen", done_seen, 1);
        if (!done_seen) begin
            drop_tile();
            rst = 1'b1;
            tick();
            rst = 1'b0;
        end
        tick();
    endtask

    initial begin
        rst               = 1'b1;
        start_i           = 1'b0;
        base_addr_i       = '0;
        row_stride_i      = '0;
        active_rows_i     = '0;
        words_per_row_i   = '0;
        ifmap_fifo_full_i = '0;
        active            = 1'b0;
        exp_busy          = 1'b0;
        done_seen         = 1'b0;
        empty_tile        = 1'b0;
        prev_rd           = 1'b0;
        prev_row          = 0;
        rsp_pend          = 1'b0;
        rsp_addr          = '0;
        tick();
        tick();
        @(negedge clk);
        check("reset_rd_en", glb_rd_en_o, 0);
        check("reset_addr", glb_addr_o, 0);
        check("reset_push", push_ifmap_en_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        tick();
        rst = 1'b0;
        tick();

        run_tile(32'h0000_0100, 32'h40, 2, 2, 0, 1'b0);
        run_tile(32'h0000_2000, 32'h80, 3, 1, 2, 1'b0);
        run_tile(32'h0000_3000, 32'h10, 1, 4, 0, 1'b0);
        run_tile(32'h0000_4000, 32'h40, 0, 3, 0, 1'b0);
        run_tile(32'h0000_5000, 32'h40, 2, 0, 0, 1'b0);

        // Reset with a read in flight: the word is dropped and no done appears.
        issue_start(32'h0000_6000, 32'h100, 4, 4);
        tick();
        tick();
        rst = 1'b1;
        drop_tile();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_push", push_ifmap_en_o, 0);
        check("post_reset_rd_en", glb_rd_en_o, 0);
        check("post_reset_busy", busy_o, 0);
        check("post_reset_done", done_o, 0);
        run_tile(32'h0000_6000, 32'h100, 4, 4, 0, 1'b0);

        run_tile(32'hFFFF_FFFC, 32'h40, 1, 2, 0, 1'b1);
        run_tile(32'hFFFF_FF00, 32'h20, 32, 2, 1, 1'b1);

        for (int k = 0; k < 20; k++) begin
            int rows, words;
            rows  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 32) : $urandom_range(0, 6);
            words = $urandom_range(0, 4);
            run_tile($urandom, $urandom, rows, words, $urandom_range(0, 1), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
